// File: rtl/pe_feeder.sv
// pe_feeder: buffers operands for one PE, streams them, collects psums.
// Optional PE_FEEDER_TIMEOUT_EN adds a watchdog on the wait states.
module pe_feeder #(
  parameter  int D_WIDTH        = 32,
  parameter  int IACT_SIZE      = 5,
  parameter  int KERNEL_SIZE    = 3,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int OUT_N = IACT_SIZE - KERNEL_SIZE + 1,
  localparam int AW    = $clog2(IACT_SIZE),
  localparam int RW    = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [AW-1:0]      wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               go,
  output logic               busy,
  output logic               run_done,
  output logic               err,
  input  logic [RW-1:0]      rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               pe_start,
  output logic [D_WIDTH-1:0] pe_iact,
  output logic [D_WIDTH-1:0] pe_weight,
  input  logic               pe_load_iact,
  input  logic               pe_load_weight,
  input  logic               pe_done,
  input  logic [D_WIDTH-1:0] pe_out
);

  typedef enum logic [2:0] {
    IDLE, START, SEND_IACT, WAIT_IACT,
    SEND_W, WAIT_W, COLLECT, FINISH
  } state_t;

  localparam logic [AW:0]   ISZ   = (AW+1)'(IACT_SIZE);
  localparam logic [AW:0]   KSZ   = (AW+1)'(KERNEL_SIZE);
  localparam logic [AW-1:0] ILAST = AW'(IACT_SIZE - 1);
  localparam logic [AW-1:0] WLAST = AW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] OLAST = RW'(OUT_N - 1);

  state_t state, state_n, state_pre;

  logic [D_WIDTH-1:0] ibuf [IACT_SIZE];
  logic [D_WIDTH-1:0] wbuf [IACT_SIZE];
  logic [D_WIDTH-1:0] res  [OUT_N];

  logic [AW-1:0] cnt;
  logic [RW-1:0] ocnt;
  logic          iact_ack;
  logic          to_hit;
  logic          accept;
  logic          take;

  assign accept   = (state == IDLE) && go;
  assign take     = (state == COLLECT) && pe_done;
  assign busy     = (state != IDLE) && (state != FINISH);
  assign run_done = (state == FINISH);
  assign pe_start = (state == START);
  assign rd_data  = res[rd_addr];

  always_comb begin
    state_pre = state;
    unique case (state)
      IDLE:      if (go) state_pre = START;
      START:     state_pre = SEND_IACT;
      SEND_IACT: if (cnt == ILAST) state_pre = WAIT_IACT;
      WAIT_IACT: if (pe_load_iact || iact_ack) state_pre = SEND_W;
      SEND_W:    if (cnt == WLAST) state_pre = WAIT_W;
      WAIT_W:    if (pe_load_weight) state_pre = COLLECT;
      COLLECT:   if (take && ocnt == OLAST) state_pre = FINISH;
      FINISH:    state_pre = IDLE;
      default:   state_pre = IDLE;
    endcase
    state_n = to_hit ? FINISH : state_pre;
  end

`ifdef PE_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wdog;
  logic          in_wait;
  logic          err_q;

  assign in_wait = (state == WAIT_IACT) || (state == WAIT_W) ||
                   (state == COLLECT);
  // Timeout only when the run would otherwise stall this cycle
  assign to_hit  = in_wait && (wdog == TLAST) && !take &&
                   (state_pre == state);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!in_wait || state_n != state || take) wdog <= '0;
      else wdog <= wdog + 1'b1;
      if (accept) err_q <= 1'b0;
      else if (to_hit) err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ocnt      <= '0;
      iact_ack  <= 1'b0;
      pe_iact   <= '0;
      pe_weight <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (state == SEND_IACT || state == SEND_W) cnt <= cnt + 1'b1;
      if (state == START) ocnt <= '0;
      else if (take) ocnt <= ocnt + 1'b1;
      if (state == START) iact_ack <= 1'b0;
      else if (state == SEND_IACT && cnt == ILAST && pe_load_iact)
        iact_ack <= 1'b1;
      if (state == START) pe_iact <= ibuf[0];
      else if (state == SEND_IACT && cnt != ILAST)
        pe_iact <= ibuf[cnt + 1'b1];
      else if (state == FINISH) pe_iact <= '0;
      if (state == WAIT_IACT && state_n == SEND_W) pe_weight <= wbuf[0];
      else if (state == SEND_W && cnt != WLAST)
        pe_weight <= wbuf[cnt + 1'b1];
      else if (state == FINISH) pe_weight <= '0;
    end
  end

  // Buffers deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      if (!wr_sel && {1'b0, wr_addr} < ISZ) ibuf[wr_addr] <= wr_data;
      if (wr_sel && {1'b0, wr_addr} < KSZ) wbuf[wr_addr] <= wr_data;
    end
    if (take) res[ocnt] <= pe_out;
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed checks of pe_feeder streaming, collect, reset.
// Build with PE_FEEDER_TIMEOUT_EN to exercise the watchdog path.
module tb_pe_feeder;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        wr_en = 0;
  logic        wr_sel = 0;
  logic [2:0]  wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic        go = 0;
  logic        busy, run_done, err;
  logic [1:0]  rd_addr = 0;
  logic [31:0] rd_data;
  logic        pe_start;
  logic [31:0] pe_iact, pe_weight;
  logic        pe_load_iact = 0;
  logic        pe_load_weight = 0;
  logic        pe_done = 0;
  logic [31:0] pe_out = 0;

  int nchk = 0;
  int nerr = 0;

  int ib [5] = '{2, 4, 6, 8, 10};
  int wb [3] = '{1, 2, 3};
  int ps [3] = '{28, 40, 52};

  pe_feeder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .busy(busy), .run_done(run_done), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .pe_start(pe_start), .pe_iact(pe_iact), .pe_weight(pe_weight),
    .pe_load_iact(pe_load_iact), .pe_load_weight(pe_load_weight),
    .pe_done(pe_done), .pe_out(pe_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int a, input int d);
    wr_en = 1; wr_sel = sel; wr_addr = 3'(a); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  // Runs from go up to the first WAIT_W cycle
  task automatic stream(input bit inj);
    go = 1;
    tick();
    go = 0;
    chk("start", pe_start, 1);
    chk("busy_on", busy, 1);
    for (int k = 0; k < 5; k++) begin
      if (inj && k == 1) begin
        go = 1; wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 99;
      end
      tick();
      go = 0; wr_en = 0;
      chk($sformatf("iact%0d", k), pe_iact, ib[k]);
      chk($sformatf("nostart%0d", k), pe_start, 0);
      chk($sformatf("now%0d", k), pe_weight, 0);
    end
    tick();
    chk("iact_hold", pe_iact, 10);
    chk("w_idle", pe_weight, 0);
    pe_load_iact = 1;
    tick();
    pe_load_iact = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      chk($sformatf("w%0d", k), pe_weight, wb[k]);
    end
    tick();
    chk("w_hold", pe_weight, 3);
    chk("busy_ww", busy, 1);
  endtask

  task automatic collect();
    pe_load_weight = 1;
    tick();
    pe_load_weight = 0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("nodone%0d", j), run_done, 0);
      pe_done = 1; pe_out = ps[j];
      tick();
    end
    pe_done = 0; pe_out = 0;
    chk("run_done", run_done, 1);
    chk("busy_off", busy, 0);
    tick();
    chk("done_pulse", run_done, 0);
    chk("iact_zero", pe_iact, 0);
    chk("w_zero", pe_weight, 0);
    for (int j = 0; j < 3; j++) begin
      rd_addr = 2'(j);
      #1;
      chk($sformatf("rd%0d", j), rd_data, ps[j]);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", run_done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", pe_start, 0);
    chk("rst_iact", pe_iact, 0);
    rst_n = 1;
    tick();
    for (int k = 0; k < 5; k++) wr(0, k, ib[k]);
    for (int k = 0; k < 3; k++) wr(1, k, wb[k]);
    wr(1, 3, 77);

    stream(0);
    collect();

    stream(1);
    collect();
    tick();
    chk("go_ignored", busy, 0);

    stream(0);
    collect();

    go = 1;
    tick();
    go = 0;
    repeat (6) tick();
    pe_load_iact = 1;
    tick();
    pe_load_iact = 0;
    chk("in_sendw", pe_weight, 1);
    rst_n = 0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_start", pe_start, 0);
    chk("ar_iact", pe_iact, 0);
    chk("ar_w", pe_weight, 0);
    chk("ar_done", run_done, 0);
    chk("ar_err", err, 0);
    tick();
    rst_n = 1;
    tick();
    stream(0);
    collect();

    pe_load_iact = 1;
    stream(0);
    pe_load_iact = 0;
    collect();

    stream(0);
    repeat (15) tick();
    chk("wd_busy", busy, 1);
    chk("wd_noerr", err, 0);
    tick();
`ifdef PE_FEEDER_TIMEOUT_EN
    chk("wd_done", run_done, 1);
    chk("wd_err", err, 1);
    tick();
    chk("wd_idle", busy, 0);
    chk("wd_sticky", err, 1);
`else
    chk("wd_hang", busy, 1);
    chk("wd_nodone", run_done, 0);
    chk("wd_err0", err, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    chk("wd_rst", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
Driver for one PE, on the opposite end of the PE's start/iact/weight/load_iact/load_weight/done/pe_out interface. A host fills local iact and weight buffers, then pulses go. The feeder starts the PE, streams the operands, and collects the output psums into a result buffer that the host can read. It sits between the global buffer controller and each PE in the array.

Parameters:
D_WIDTH, 32, data width of iact, weight, psum and host buses
IACT_SIZE, 5, iact words streamed per run
KERNEL_SIZE, 3, weight words streamed per run
OUT_N, IACT_SIZE-KERNEL_SIZE+1, psums collected per run (localparam)
TIMEOUT_CYCLES, 256, watchdog limit, used only with PE_FEEDER_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host buffer write strobe
wr_sel  in  1  0 = iact buffer, 1 = weight buffer
wr_addr  in  clog2(IACT_SIZE)  write index (range-checked per buffer)
wr_data  in  D_WIDTH  write data
go  in  1  run request, single-cycle pulse
busy  out  1  high from go acceptance until the run ends
run_done  out  1  one-cycle pulse at end of run
err  out  1  sticky watchdog error, cleared by next accepted go
rd_addr  in  clog2(OUT_N)  result read index
rd_data  out  D_WIDTH  result[rd_addr], combinational read
pe_start  out  1  to PE start
pe_iact  out  D_WIDTH  to PE iact
pe_weight  out  D_WIDTH  to PE weight
pe_load_iact  in  1  PE has all iacts
pe_load_weight  in  1  PE has all weights
pe_done  in  1  one-cycle pulse per valid psum
pe_out  in  D_WIDTH  psum, valid while pe_done is high

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE
  - busy, run_done, err, pe_start = 0
  - pe_iact, pe_weight = 0
  - counters = 0
  - buffers are not cleared
- IDLE:
  - go=1 -> START, busy=1, err=0.
  - go while busy is ignored.
  - Host writes are accepted only in IDLE. Writes while busy are dropped.
  - Out-of-range wr_addr (weight buffer: >= KERNEL_SIZE) is dropped.
- START:
  - pe_start=1 for exactly one cycle -> SEND_IACT.
- SEND_IACT:
  - pe_iact = ibuf[k] for k = 0..IACT_SIZE-1, one word per cycle, starting the cycle after pe_start.
  - After the last word -> WAIT_IACT.
- WAIT_IACT:
  - pe_iact holds the last word.
  - pe_load_iact=1 -> SEND_W on the next cycle.
  - If pe_load_iact is already high during the last SEND_IACT cycle, it is honoured (no deadlock).
- SEND_W:
  - pe_weight = wbuf[k] for k = 0..KERNEL_SIZE-1, one word per cycle.
  - After the last word -> WAIT_W.
- WAIT_W:
  - pe_weight holds the last word.
  - pe_load_weight=1 -> COLLECT.
- COLLECT:
  - Each cycle with pe_done=1: result[ocnt] <= pe_out; ocnt++.
  - The pe_done that brings ocnt to OUT_N -> FINISH.
  - pe_done outside COLLECT is ignored.
- FINISH:
  - run_done=1 for one cycle, busy=0 -> IDLE.
  - rd_data reflects new results from the cycle after run_done.
- go arriving in the same cycle as run_done is ignored. A new go is accepted in IDLE only.
- Results persist until overwritten by the next run. There is no arithmetic on the data; widths pass straight through.
- pe_iact and pe_weight return to 0 on entering IDLE.

Optional Feature:
Macro: PE_FEEDER_TIMEOUT_EN.
- With it defined:
  - A watchdog counts cycles spent in WAIT_IACT, WAIT_W or COLLECT. It resets on each state entry and on each pe_done.
  - On reaching TIMEOUT_CYCLES: err=1 (sticky), then FINISH, where run_done still pulses.
  - Partially collected results remain readable.
- Without it:
  - No counter logic exists.
  - err is tied to 0.
  - The wait states wait indefinitely.

Test Plan:
1. Write ibuf = {2,4,6,8,10} and wbuf = {1,2,3}, pulse go. Expected:
   - pe_start is high one cycle.
   - pe_iact shows 2,4,6,8,10 on the five following cycles, then holds 10.
   - After the PE model raises load_iact, pe_weight shows 1,2,3.
2. PE model returns done pulses with pe_out = 28, 40, 52. Expected: run_done pulses once, busy falls, rd_data[0..2] = 28, 40, 52.
3. go pulsed while busy, and wr_en while busy (wr_data = 99 to ibuf[0]). Expected: both ignored; the next run still streams 2 first.
4. rst_n driven low during SEND_W. Expected: all outputs go to 0 immediately, state is IDLE, buffers are retained; a fresh go reruns scenario 1 correctly.
5. pe_load_iact held high from the start of streaming. Expected: all 5 iacts are still sent before any weight.
6. With PE_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, the PE never asserts load_weight. Expected: err=1 and run_done after 16 cycles in WAIT_W; without the macro, busy stays high.
